// File: rtl/mux_rr_arb_pkg.sv
// Shared types for mux_rr_arb: lock FSM state and mode encodings.
package mux_rr_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first asserted req at or above ptr, wrapping at N.
module rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(ptr) + k) % N);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel mux with fixed-select or round-robin arbitration and a registered output.
// Define MUX_RR_ARB_LOCK_EN to hold the grant across multi-beat packets (ended by in_last).
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4,
  localparam int unsigned SelW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SelW-1:0]   sel,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [SelW-1:0]   out_ch
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SelW-1:0] out_ch_q, out_ch_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [SelW-1:0] rr_idx, gnt_idx, lock_ch;
  logic            rr_vld, gnt_vld, accept, xfer, locked;

  rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

`ifdef MUX_RR_ARB_LOCK_EN
  lock_state_e     lock_q, lock_d;
  logic [SelW-1:0] lock_ch_q, lock_ch_d;

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      unique case (lock_q)
        UNLOCKED: begin
          if (!in_last[gnt_idx]) begin
            lock_d    = LOCKED;
            lock_ch_d = gnt_idx;
          end
        end
        LOCKED: begin
          if (in_last[gnt_idx]) lock_d = UNLOCKED;
        end
        default: lock_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= UNLOCKED;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign locked  = (lock_q == LOCKED);
  assign lock_ch = lock_ch_q;
`else
  logic unused_last;
  assign unused_last = ^in_last;
  assign locked      = 1'b0;
  assign lock_ch     = '0;
`endif

  // A held lock overrides both mode and sel.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (locked) begin
      gnt_idx = lock_ch;
      gnt_vld = 1'b1;
    end else if (mode == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_vld = rr_vld;
    end else begin
      gnt_idx = sel;
      gnt_vld = (32'(sel) < N);
    end
  end

  assign accept = ~out_valid_q | out_ready;
  assign xfer   = gnt_vld & accept & in_valid[gnt_idx];

  always_comb begin
    in_ready = '0;
    if (gnt_vld && accept && rst_n) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(gnt_idx) * W +: W];
      out_ch_d    = gnt_idx;
      if (mode == MODE_RR && !locked) begin
        ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed self-checking bench for mux_rr_arb (N=4, W=4); lock cases need MUX_RR_ARB_LOCK_EN.
module tb_mux_rr_arb;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;

  logic [W-1:0] ch_dat [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_rr_arb #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ch_dat[0] = 4'h3;
    ch_dat[1] = 4'h5;
    ch_dat[2] = 4'hA;
    ch_dat[3] = 4'hD;
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = {ch_dat[3], ch_dat[2], ch_dat[1], ch_dat[0]};
    in_last   = 4'b0000;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_data", 32'(out_data), 32'h0);
    check_eq("rst_out_ch", 32'(out_ch), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Fixed select of ch2
    mode = 1'b0;
    sel  = 2'd2;
    #1;
    check_eq("fix_in_ready", 32'(in_ready), 32'b0100);
    step();
    check_eq("fix_out_valid", 32'(out_valid), 32'h1);
    check_eq("fix_out_data", 32'(out_data), 32'hA);
    check_eq("fix_out_ch", 32'(out_ch), 32'h2);

    // Fixed select grants sel even when that channel is idle
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    check_eq("fix_idle_ready", 32'(in_ready), 32'b0010);
    step();
    check_eq("fix_idle_drain", 32'(out_valid), 32'h0);

    // RR from ptr=0 with only ch3 valid, then wrap back to ch0
    mode     = 1'b1;
    in_valid = 4'b1000;
    #1;
    check_eq("rr_ch3_ready", 32'(in_ready), 32'b1000);
    step();
    check_eq("rr_ch3_ch", 32'(out_ch), 32'h3);
    check_eq("rr_ch3_data", 32'(out_data), 32'hD);
    in_valid = 4'b1111;
    #1;
    check_eq("rr_wrap_ready", 32'(in_ready), 32'b0001);

    // All valid: 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      check_eq("rr_seq_ready", 32'(in_ready), 32'(1 << (i % 4)));
      step();
      check_eq("rr_seq_valid", 32'(out_valid), 32'h1);
      check_eq("rr_seq_ch", 32'(out_ch), 32'(i % 4));
      check_eq("rr_seq_data", 32'(out_data), 32'(ch_dat[i % 4]));
    end

    // Backpressure holds output; ptr now 1
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", 32'(in_ready), 32'h0);
      step();
      check_eq("bp_out_valid", 32'(out_valid), 32'h1);
      check_eq("bp_out_data", 32'(out_data), 32'h3);
      check_eq("bp_out_ch", 32'(out_ch), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_rel_ready", 32'(in_ready), 32'b0010);
    step();
    check_eq("bp_rel_ch1", 32'(out_ch), 32'h1);
    check_eq("bp_rel_data1", 32'(out_data), 32'h5);
    check_eq("bp_rel_ready2", 32'(in_ready), 32'b0100);
    step();
    check_eq("bp_rel_ch2", 32'(out_ch), 32'h2);
    check_eq("bp_rel_valid2", 32'(out_valid), 32'h1);

    // Mode change takes effect immediately; fixed mode leaves ptr at 3
    mode = 1'b0;
    sel  = 2'd3;
    #1;
    check_eq("mode_sw_ready", 32'(in_ready), 32'b1000);
    step();
    check_eq("mode_sw_ch", 32'(out_ch), 32'h3);
    mode = 1'b1;
    #1;
    check_eq("ptr_held_ready", 32'(in_ready), 32'b1000);
    step();
    check_eq("ptr_held_ch", 32'(out_ch), 32'h3);

    // Move ptr to 1
    in_valid = 4'b0001;
    step();
    check_eq("ptr1_ch", 32'(out_ch), 32'h0);

`ifdef MUX_RR_ARB_LOCK_EN
    // ch1 3-beat packet while ch0/ch2 compete; mode/sel changes ignored while locked
    in_valid = 4'b0111;
    in_last  = 4'b0000;
    #1;
    check_eq("lock_b1_ready", 32'(in_ready), 32'b0010);
    step();
    check_eq("lock_b1_ch", 32'(out_ch), 32'h1);
    mode = 1'b0;
    sel  = 2'd0;
    #1;
    check_eq("lock_b2_ready", 32'(in_ready), 32'b0010);
    step();
    check_eq("lock_b2_ch", 32'(out_ch), 32'h1);
    in_last = 4'b0010;
    step();
    check_eq("lock_b3_ch", 32'(out_ch), 32'h1);
    mode    = 1'b1;
    in_last = 4'b0000;
    #1;
    check_eq("unlock_ready", 32'(in_ready), 32'b0100);
    step();
    check_eq("unlock_ch", 32'(out_ch), 32'h2);
`endif

    // Start a packet on ch3, then reset mid-packet
    mode     = 1'b0;
    sel      = 2'd3;
    in_valid = 4'b1111;
    in_last  = 4'b0000;
    step();
    check_eq("pre_rst_ch", 32'(out_ch), 32'h3);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'h0);
    #3;
    rst_n = 1'b1;
    mode  = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'b0001);
    step();
    check_eq("post_rst_valid", 32'(out_valid), 32'h1);
    check_eq("post_rst_ch", 32'(out_ch), 32'h0);
    check_eq("post_rst_data", 32'(out_data), 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
